// File: rtl/booth_seq_unit_if.sv
// Operand/product bus of the sequential Booth multiplier.
// The master drives start and operands; the slave returns product halves and status.
interface booth_seq_unit_if #(
  parameter int width = 8
);
  logic             start;
  logic [width-1:0] inbus;
  logic [width-1:0] outbus;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start,
    output inbus,
    input  outbus,
    input  out_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  inbus,
    output outbus,
    output out_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/booth_seq_unit.sv
// Sequential signed radix-2 Booth multiplier: operands arrive on consecutive cycles
// after start, the 2*width product leaves as high half then low half.
module booth_seq_unit #(
  parameter int width = 8
) (
  input  logic              clk,
  input  logic              reset,
  booth_seq_unit_if.slave   bus
);

  localparam int cw = (width > 2) ? $clog2(width) : 1;
  localparam logic [cw-1:0] cnt_last = cw'(width - 1);
  localparam logic [cw-1:0] cnt_one  = {{(cw-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_M = 3'd1,
    S_LOAD_Q = 3'd2,
    S_ADD    = 3'd3,
    S_SHIFT  = 3'd4,
    S_OUT_HI = 3'd5,
    S_OUT_LO = 3'd6
  } state_t;

  state_t           state_r;
  logic [width-1:0] m_r;
  logic [width-1:0] q_r;
  logic             q1_r;
  logic [width:0]   a_r;
  logic [cw-1:0]    cnt_r;
  logic [width-1:0] outbus_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             done_r;

  logic [width:0]   m_ext_s;
  logic [width:0]   a_add_s;
  logic [width:0]   a_sub_s;
  logic [width:0]   a_shr_s;
  logic [width-1:0] q_shr_s;

  // Datapath candidates for the add/subtract step and the arithmetic right shift.
  always_comb begin
    m_ext_s = {m_r[width-1], m_r};
    a_add_s = a_r + m_ext_s;
    a_sub_s = a_r - m_ext_s;
    a_shr_s = {a_r[width], a_r[width:1]};
    q_shr_s = {a_r[0], q_r[width-1:1]};
  end

  // Control FSM with datapath registers; outputs are registered against the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      m_r         <= {width{1'b0}};
      q_r         <= {width{1'b0}};
      q1_r        <= 1'b0;
      a_r         <= {(width+1){1'b0}};
      cnt_r       <= {cw{1'b0}};
      outbus_r    <= {width{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      outbus_r    <= {width{1'b0}};
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b1;
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            state_r <= S_LOAD_M;
          end else begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
        end
        S_LOAD_M: begin
          m_r     <= bus.inbus;
          state_r <= S_LOAD_Q;
        end
        S_LOAD_Q: begin
          q_r     <= bus.inbus;
          a_r     <= {(width+1){1'b0}};
          q1_r    <= 1'b0;
          cnt_r   <= {cw{1'b0}};
          state_r <= S_ADD;
        end
        S_ADD: begin
          case ({q_r[0], q1_r})
            2'b01:   a_r <= a_add_s;
            2'b10:   a_r <= a_sub_s;
            default: a_r <= a_r;
          endcase
          state_r <= S_SHIFT;
        end
        S_SHIFT: begin
          a_r   <= a_shr_s;
          q_r   <= q_shr_s;
          q1_r  <= q_r[0];
          cnt_r <= cnt_r + cnt_one;
          if (cnt_r == cnt_last) begin
            state_r     <= S_OUT_HI;
            outbus_r    <= a_shr_s[width-1:0];
            out_valid_r <= 1'b1;
          end else begin
            state_r <= S_ADD;
          end
        end
        S_OUT_HI: begin
          state_r     <= S_OUT_LO;
          outbus_r    <= q_r;
          out_valid_r <= 1'b1;
          done_r      <= 1'b1;
        end
        S_OUT_LO: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.outbus    = outbus_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_booth_seq_unit.sv
// Scoreboard bench for booth_seq_unit: directed corner products plus randomized
// operands, expected products from plain signed multiplication.
module tb_booth_seq_unit;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   failed = 0;
  exp_t sb_q[$];
  bit   phase = 1'b0;

  booth_seq_unit_if #(.width(W)) bus ();

  booth_seq_unit #(.width(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    failed++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    int   sa;
    int   sb;
    int   p;
    sa = $signed(a);
    sb = $signed(b);
    p  = sa * sb;
    r.hi = p[2*W-1:W];
    r.lo = p[W-1:0];
    return r;
  endfunction

  function automatic logic [W-1:0] rnd();
    return W'($urandom_range(0, (1 << W) - 1));
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a product half.
  always @(negedge clk) begin
    if (reset) begin
      phase = 1'b0;
    end else if (bus.out_valid) begin
      if (sb_q.size() == 0) begin
        fail_now("unexpected_output");
      end else if (!phase) begin
        check("out_hi", bus.outbus, sb_q[0].hi);
        check("done_in_hi", bus.done, 1'b0);
        phase = 1'b1;
      end else begin
        check("out_lo", bus.outbus, sb_q[0].lo);
        check("done_in_lo", bus.done, 1'b1);
        void'(sb_q.pop_front());
        phase = 1'b0;
      end
    end else if (bus.done) begin
      fail_now("done_without_valid");
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) fail_now("idle_timeout");
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold, input bit noise);
    int e;
    bit seen;
    bit busy_ok;
    wait_idle();
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.inbus = noise ? rnd() : '0;
    @(posedge clk); #1;               // edge 0: start sampled
    if (!hold) bus.start = 1'b0;
    bus.inbus = a;
    sb_q.push_back(model(a, b));
    @(posedge clk); #1;               // edge 1: multiplicand captured
    bus.inbus = b;
    @(posedge clk); #1;               // edge 2: multiplier captured
    bus.inbus = noise ? rnd() : '0;
    e = 2;
    seen = 1'b0;
    busy_ok = 1'b1;
    while (!seen && e < 100) begin
      @(negedge clk);
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        e++;
        #1;
        if (noise) bus.inbus = rnd();
      end
    end
    if (seen) check("done_edge", e, 2 * W + 3);
    else fail_now("done_timeout");
    if (hold) begin
      check("busy_continuous", busy_ok, 1'b1);
      bus.start = 1'b0;
    end
    bus.inbus = '0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.inbus = '0;
    #12;
    check("rst_outbus", bus.outbus, '0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_op(8'h03, 8'h05, 1'b0, 1'b0);
    run_op(8'hFD, 8'h05, 1'b0, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 1'b0);
    run_op(8'h7F, 8'h81, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("no_restart_after_hold", bus.busy, 1'b0);

    // Abort an operation with reset at edge 8.
    wait_idle();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.inbus = 8'h09;
    sb_q.push_back(model(8'h09, 8'h03));
    @(posedge clk); #1;
    bus.inbus = 8'h03;
    repeat (7) @(posedge clk);
    #1;
    check("busy_before_abort", bus.busy, 1'b1);
    reset = 1'b1;
    sb_q.delete();
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_outbus", bus.outbus, '0);
    check("abort_out_valid", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_reset", bus.busy, 1'b0);
    run_op(8'h02, 8'h02, 1'b0, 1'b0);

    run_op(8'h06, 8'h07, 1'b0, 1'b1);

    for (int i = 0; i < 20; i++) begin
      run_op(rnd(), rnd(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
    end

    repeat (30) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/booth_seq_unit.md
BOOTH_SEQ_UNIT -- requirements
Module: booth_seq_unit

Interface
REQ-001 SHALL have parameter: width, default 8, operand width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  begin-operation request, sampled only in IDLE.
REQ-005 SHALL have port: inbus  input  width  operand input; multiplicand, then multiplier, on consecutive cycles.
REQ-006 SHALL have port: outbus  output  width  product output; high half, then low half.
REQ-007 SHALL have port: out_valid  output  1  high while outbus carries a product half.
REQ-008 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port: done  output  1  one-cycle pulse, high during the low-half output cycle.

Function
REQ-010 SHALL implement signed (two's complement) width x width -> 2*width radix-2 Booth multiplication.
REQ-011 SHALL hold these internal registers: M (width bits), Q (width bits), Q_1 (1 bit), A (width+1 bits, sign-extended so that A-M with M = -2^(width-1) cannot overflow), and cnt (clog2(width) bits).
REQ-012 SHALL implement states IDLE, LOAD_M, LOAD_Q, ADD, SHIFT, OUT_HI, OUT_LO, with transitions as defined in REQ-013 to REQ-019.
REQ-013 SHALL, in IDLE, transition to LOAD_M on a clock edge with start=1, and otherwise remain in IDLE.
REQ-014 SHALL, in LOAD_M, capture M <= inbus at the next edge and transition to LOAD_Q.
REQ-015 SHALL, in LOAD_Q, at the next edge: capture Q <= inbus; clear A, Q_1 and cnt; transition to ADD.
REQ-016 SHALL, in ADD, select by {Q[0],Q_1}: 01 -> A <= A+M (sign-extended); 10 -> A <= A-M; 00 or 11 -> A unchanged; then transition to SHIFT.
REQ-017 SHALL, in SHIFT, arithmetically shift {A,Q,Q_1} right by 1 (A MSB replicated) and increment cnt.
REQ-018 SHALL, from SHIFT, go to OUT_HI when cnt was width-1 before the increment, and otherwise return to ADD.
REQ-019 SHALL transition OUT_HI -> OUT_LO -> IDLE, one cycle each.
REQ-020 SHALL drive outbus = A[width-1:0] and out_valid=1 in OUT_HI.
REQ-021 SHALL drive outbus = Q, out_valid=1 and done=1 in OUT_LO.
REQ-022 SHALL drive outbus=0, out_valid=0 and done=0 in all states other than OUT_HI and OUT_LO; these outputs are decoded from state only.
REQ-023 SHALL have the following latency, with start sampled at edge 0: M sampled at edge 1; Q sampled at edge 2; OUT_HI entered at edge 2*width+2; OUT_LO entered at edge 2*width+3 (edge 19 for width=8).
REQ-024 SHALL ignore start while busy=1, including when start is held high continuously; after OUT_LO, the unit returns to IDLE and a new start is accepted from the next edge.
REQ-025 SHALL make the product equal to {A[width-1:0],Q}, exact for all signed operand pairs, including -2^(width-1) x -2^(width-1).
REQ-026 SHALL ignore inbus in every state except LOAD_M and LOAD_Q.

Reset
REQ-027 SHALL, on reset assertion at any time (including mid-operation), immediately force state=IDLE and clear M, Q, Q_1, A and cnt to 0, without waiting for a clock edge.
REQ-028 SHALL hold outbus=0, out_valid=0, busy=0 and done=0 while reset=1.
REQ-029 SHALL, after reset deasserts, remain in IDLE until start=1 is sampled; any operation in progress at reset is discarded.

Verification
REQ-030 SHALL cover: start, inbus=3 then 5 -> OUT_HI outbus=0x00, OUT_LO outbus=0x0F, done high at edge 19 only.
REQ-031 SHALL cover: inbus=0xFD (-3) then 0x05 -> outbus 0xFF then 0xF1 (-15).
REQ-032 SHALL cover: inbus=0x80 then 0x80 (-128 x -128) -> outbus 0x40 then 0x00 (16384).
REQ-033 SHALL cover: 0x7F x 0x81 (127 x -127) -> outbus 0xC0 then 0xFF (-16129), with start held high throughout -> exactly one operation per IDLE visit and busy continuous.
REQ-034 SHALL cover: reset asserted at edge 8 of an operation -> busy=0 and outbus=0 immediately; a following 2 x 2 operation -> outbus 0x00 then 0x04.
REQ-035 SHALL cover: inbus toggled randomly outside LOAD_M and LOAD_Q during 6 x 7 -> outbus 0x00 then 0x2A, unaffected by the toggling.
